// File: rtl/reg_display_sched.sv
// Debug display scheduler: debounces the step button, cycles through the six
// register pairs (manually or on a timer), and snapshots the selected pair.
module reg_display_sched #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_CYCLES     = 50000000,
  parameter int REFRESH_CYCLES  = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_btn_n,
  input  logic        auto_en,
  input  logic        freeze,
  input  logic [7:0]  regA,
  input  logic [7:0]  regF,
  input  logic [7:0]  regB,
  input  logic [7:0]  regC,
  input  logic [7:0]  regD,
  input  logic [7:0]  regE,
  input  logic [7:0]  regH,
  input  logic [7:0]  regL,
  input  logic [15:0] regSP,
  input  logic [15:0] regPC,
  output logic [7:0]  disp_hi,
  output logic [7:0]  disp_lo,
  output logic [2:0]  sel,
  output logic        step_pulse
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AU_W = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam int RF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AU_W-1:0] AU_LAST = AU_W'(AUTO_CYCLES - 1);
  localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_CYCLES - 1);

  logic            sync1_reg;
  logic            sync2_reg;
  logic            db_state_reg;
  logic [DB_W-1:0] db_cnt_reg;
  logic [AU_W-1:0] auto_cnt_reg;
  logic [RF_W-1:0] ref_cnt_reg;
  logic            step_pulse_reg;
  logic [2:0]      sel_reg;
  logic            sel_chg_reg;
  logic [7:0]      disp_hi_reg;
  logic [7:0]      disp_lo_reg;

  logic            pressed_raw;
  logic            db_flip;
  logic            auto_tick;
  logic            refresh_tick;
  logic            advance;
  logic [15:0]     pair_mux;

  always_comb begin
    pressed_raw  = ~sync2_reg;
    db_flip      = (pressed_raw != db_state_reg) && (db_cnt_reg == DB_LAST);
    auto_tick    = auto_en && (auto_cnt_reg == AU_LAST);
    refresh_tick = (ref_cnt_reg == RF_LAST);
    // A button press and a timer tick in the same cycle still move one step.
    advance      = step_pulse_reg | auto_tick;
    case (sel_reg)
      3'd0:    pair_mux = {regA, regF};
      3'd1:    pair_mux = {regB, regC};
      3'd2:    pair_mux = {regD, regE};
      3'd3:    pair_mux = {regH, regL};
      3'd4:    pair_mux = regSP;
      3'd5:    pair_mux = regPC;
      default: pair_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg      <= 1'b1;
      sync2_reg      <= 1'b1;
      db_state_reg   <= 1'b0;
      db_cnt_reg     <= '0;
      auto_cnt_reg   <= '0;
      ref_cnt_reg    <= '0;
      step_pulse_reg <= 1'b0;
      sel_reg        <= 3'd0;
      sel_chg_reg    <= 1'b0;
      disp_hi_reg    <= 8'h00;
      disp_lo_reg    <= 8'h00;
    end else begin
      sync1_reg <= step_btn_n;
      sync2_reg <= sync1_reg;

      // Any sample agreeing with the debounced level restarts the stability count.
      if (pressed_raw == db_state_reg) begin
        db_cnt_reg <= '0;
      end else if (db_flip) begin
        db_cnt_reg   <= '0;
        db_state_reg <= pressed_raw;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
      step_pulse_reg <= db_flip & pressed_raw;

      if (!auto_en || step_pulse_reg || auto_tick)
        auto_cnt_reg <= '0;
      else
        auto_cnt_reg <= auto_cnt_reg + 1'b1;

      if (refresh_tick)
        ref_cnt_reg <= '0;
      else
        ref_cnt_reg <= ref_cnt_reg + 1'b1;

      if (advance)
        sel_reg <= (sel_reg == 3'd5) ? 3'd0 : sel_reg + 3'd1;
      sel_chg_reg <= advance;

      if ((refresh_tick || sel_chg_reg) && !freeze) begin
        disp_hi_reg <= pair_mux[15:8];
        disp_lo_reg <= pair_mux[7:0];
      end
    end
  end

  assign disp_hi    = disp_hi_reg;
  assign disp_lo    = disp_lo_reg;
  assign sel        = sel_reg;
  assign step_pulse = step_pulse_reg;

endmodule

// File: doc/reg_display_sched.md
Name: reg_display_sched

Overview:
- Schedules the four-digit seven-segment debug display shared by all datapath registers.
- Selects one 16-bit register pair (AF, BC, DE, HL, SP, PC) and snapshots its value at a fixed refresh rate.
- Advances the selection on a debounced push-button press, or automatically on a timer.
- Drives the two 8-bit display bytes that feed the per-digit hex decoders; the hex decoders themselves are outside this block.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized samples required to accept a button level change (20 ms at 50 MHz).
- AUTO_CYCLES, 50000000: clk cycles between automatic selection advances.
- REFRESH_CYCLES, 5000000: clk cycles between display snapshots.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- step_btn_n  in  1  raw push-button, active-low, asynchronous to clk
- auto_en  in  1  1 = automatic cycling enabled
- freeze  in  1  1 = hold the current snapshot
- regA, regF, regB, regC, regD, regE, regH, regL  in  8 each  datapath registers
- regSP, regPC  in  16 each  stack pointer and program counter
- disp_hi  out  8  upper byte shown on HEX3/HEX2
- disp_lo  out  8  lower byte shown on HEX1/HEX0
- sel  out  3  current selection, 0..5
- step_pulse  out  1  one-cycle pulse per accepted button press

Behaviour:
- Reset (async, active-high) values:
  - sync flops = 1 (button released).
  - Debounced state = released.
  - All counters = 0.
  - sel=0, disp_hi=0, disp_lo=0, step_pulse=0.
- Synchronizer: two flops on step_btn_n; pressed_raw = ~sync2.
- Debounce:
  - Counter increments each cycle while pressed_raw differs from the debounced state.
  - Counter clears to 0 on any cycle where they agree.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced state flips and the counter clears.
  - step_pulse=1 for exactly the cycle after a released->pressed flip.
  - A pressed->released flip produces no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES never flip the state.
- Auto timer:
  - While auto_en=0: held at 0.
  - While auto_en=1: counts 0..AUTO_CYCLES-1; auto_tick=1 in the cycle it equals AUTO_CYCLES-1, then it wraps to 0.
  - step_pulse restarts the timer at 0.
- Selection:
  - advance = step_pulse OR auto_tick.
  - On advance, sel <= (sel==5) ? 0 : sel+1.
  - Simultaneous step_pulse and auto_tick advance sel by exactly one.
  - Mapping: 0 A/F, 1 B/C, 2 D/E, 3 H/L, 4 SP[15:8]/SP[7:0], 5 PC[15:8]/PC[7:0] (hi/lo).
- Refresh timer:
  - Free-running 0..REFRESH_CYCLES-1; refresh_tick fires at REFRESH_CYCLES-1.
  - Runs regardless of freeze.
- Snapshot:
  - disp_hi/disp_lo load the mux output for the current sel when (refresh_tick OR sel changed last cycle) AND freeze=0.
  - Latency: sel updates 1 cycle after advance; disp_* update 1 cycle after sel.
  - While freeze=1, disp_* hold, but sel still advances.
  - Deasserting freeze makes the next refresh_tick load the current sel. No immediate load unless sel changed in the cycle just before the deassertion.
- Register inputs are sampled only at snapshot loads, so datapath changes between loads are invisible.
- Reset asserted mid-operation (debounce or timer counts in progress): everything returns to reset values immediately. After release, a button already held down needs a full DEBOUNCE_CYCLES of stable low before a pulse is produced.

Test Plan (DEBOUNCE_CYCLES=4, AUTO_CYCLES=8, REFRESH_CYCLES=3):
1. Reset while regA=8'h12, regF=8'hB0 -> sel=0, disp=00/00. After the first refresh_tick -> disp_hi=12, disp_lo=B0.
2. Hold step_btn_n=0 for 10 cycles -> exactly one step_pulse, 6 cycles after the first low sample (2 sync + 4 debounce). sel=1 the next cycle; disp shows regB/regC one cycle later.
3. Low pulses of 3 cycles separated by 1-cycle highs, repeated 5 times -> no step_pulse; sel stays 0.
4. auto_en=1 from sel=4 -> sel=5 after 8 cycles, sel=0 after 16. A step_pulse landing on an auto_tick cycle advances by one only and restarts the timer.
5. regPC=16'hC0DE, sel=5, freeze=1, then regPC changes to 16'h0150 -> disp holds C0/DE. After freeze=0 -> disp=01/50 at the next refresh_tick.
6. Assert rst mid-debounce with the button held and sel=3 -> sel=0, disp=0 immediately. The held button yields one pulse 6 cycles after rst deasserts.
